// File: rtl/shift_seq_pkg.sv
// Shared opcode and state encodings for the shift command sequencer.
// The shift datapath bench imports these as well.
package shift_seq_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHL      = 2'b01;
    localparam logic [1:0] OP_SHR      = 2'b10;
    localparam logic [1:0] OP_PINGPONG = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/shift_amt_counter.sv
// Loadable down-counter that paces a shift burst. last_o flags the final
// strobe cycle (count == 1) so the FSM can leave without an extra cycle.
module shift_amt_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority over decrement; never wrap below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command-driven controller for the shift datapath: accepts one command over
// valid/ready and turns it into a counted burst of load/shift strobes, with
// ping-pong mode, abort and illegal-amount rejection. Every output is a flop;
// the output flops are fed from the next-state decode so the strobes line up
// with the state they belong to.
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 5,
    parameter int MAX_SHIFT = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             dp_load,
    output logic             dp_shift_left,
    output logic             dp_shift_right,
    output logic [WIDTH-1:0] dp_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(MAX_SHIFT);

    state_e           state_q, state_d;
    logic             pp_q, pp_d;         // ping-pong: SHR phase still to come
    logic [CNT_W-1:0] amt_q, amt_d;       // amount kept for the SHR reload
    logic [WIDTH-1:0] data_q, data_d;

    logic             ready_q, ready_d;
    logic             load_q, load_d;
    logic             shl_q, shl_d;
    logic             shr_q, shr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_last;

    shift_amt_counter #(
        .CNT_W (CNT_W)
    ) u_amt_counter (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (cnt_load_val),
        .last_o     (cnt_last)
    );

    // Next-state, counter control and next output values.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        pp_d         = pp_q;
        amt_d        = amt_q;
        data_d       = data_q;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = cmd_amt;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_LOAD) begin
                        data_d  = cmd_data;
                        state_d = LOAD;
                    end else if (cmd_amt > MAX_AMT) begin
                        err_d = 1'b1;
                    end else if (cmd_amt == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_load = 1'b1;
                        amt_d    = cmd_amt;
                        pp_d     = (cmd_op == OP_PINGPONG);
                        state_d  = (cmd_op == OP_SHR) ? SHR : SHL;
                    end
                end
            end
            LOAD: begin
                state_d = abort ? IDLE : DONE;
            end
            SHL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        if (pp_q) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = amt_q;
                            pp_d         = 1'b0;
                            state_d      = SHR;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            SHR: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        load_d  = (state_d == LOAD);
        shl_d   = (state_d == SHL);
        shr_d   = (state_d == SHR);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State and output registers.
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    // NOTE: every flop, including the data register, has a reset value so
    // outputs are defined immediately when reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pp_q    <= 1'b0;
            amt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            load_q  <= 1'b0;
            shl_q   <= 1'b0;
            shr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pp_q    <= pp_d;
            amt_q   <= amt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            load_q  <= load_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready      = ready_q;
    assign dp_load        = load_q;
    assign dp_shift_left  = shl_q;
    assign dp_shift_right = shr_q;
    assign dp_data        = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer. Each issued command pushes its
// expected per-cycle output trace into a queue; the trace is popped and
// compared one cycle at a time on the falling edge.
module tb_shift_cmd_sequencer;
    import shift_seq_pkg::*;

    localparam int WIDTH     = 8;
    localparam int CNT_W     = 5;
    localparam int MAX_SHIFT = 18;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic             dp_load;
    logic             dp_shift_left;
    logic             dp_shift_right;
    logic [WIDTH-1:0] dp_data;
    logic             busy;
    logic             done;
    logic             err;

    typedef struct packed {
        logic             ready;
        logic             busy;
        logic             done;
        logic             err;
        logic             ld;
        logic             shl;
        logic             shr;
        logic [WIDTH-1:0] data;
    } obs_t;

    obs_t             exp_q[$];
    logic [WIDTH-1:0] model_data;
    int               checks;
    int               failures;

    shift_cmd_sequencer #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .MAX_SHIFT (MAX_SHIFT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_amt        (cmd_amt),
        .cmd_data       (cmd_data),
        .abort          (abort),
        .dp_load        (dp_load),
        .dp_shift_left  (dp_shift_left),
        .dp_shift_right (dp_shift_right),
        .dp_data        (dp_data),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t sample();
        obs_t o;
        o.ready = cmd_ready;
        o.busy  = busy;
        o.done  = done;
        o.err   = err;
        o.ld    = dp_load;
        o.shl   = dp_shift_left;
        o.shr   = dp_shift_right;
        o.data  = dp_data;
        return o;
    endfunction

    function automatic obs_t mk(logic ready, logic bsy, logic dn, logic er,
                                logic ld, logic shl, logic shr);
        obs_t o;
        o.ready = ready;
        o.busy  = bsy;
        o.done  = dn;
        o.err   = er;
        o.ld    = ld;
        o.shl   = shl;
        o.shr   = shr;
        o.data  = model_data;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_n(input obs_t o, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endtask

    // Offer one command; it must be accepted on the next rising edge.
    // abort_acc drives abort during the accept cycle; abort_at > 0 models an
    // abort raised during that strobe cycle of a SHL burst.
    task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] amt,
                         input logic [WIDTH-1:0] d, input logic abort_acc,
                         input int abort_at);
        @(negedge clk);
        check("ready_before_accept", sample(), mk(1, 0, 0, 0, 0, 0, 0));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = d;
        abort     = abort_acc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        if (op == OP_LOAD) begin
            model_data = d;
            push_n(mk(0, 1, 0, 0, 1, 0, 0), 1);
            push_n(mk(0, 1, 1, 0, 0, 0, 0), 1);
        end else if (int'(amt) > MAX_SHIFT) begin
            push_n(mk(1, 0, 0, 1, 0, 0, 0), 1);
        end else if (amt == '0) begin
            push_n(mk(0, 1, 1, 0, 0, 0, 0), 1);
        end else if (abort_at > 0) begin
            push_n(mk(0, 1, 0, 0, 0, 1, 0), abort_at);
            push_n(mk(1, 0, 0, 0, 0, 0, 0), 1);
        end else begin
            if (op != OP_SHR) push_n(mk(0, 1, 0, 0, 0, 1, 0), int'(amt));
            if (op != OP_SHL) push_n(mk(0, 1, 0, 0, 0, 0, 1), int'(amt));
            push_n(mk(0, 1, 1, 0, 0, 0, 0), 1);
        end
        push_n(mk(1, 0, 0, 0, 0, 0, 0), 1);
    endtask

    // Pop and compare up to n entries (n < 0: all); raises abort after the
    // compare of cycle abort_at.
    task automatic drain(input string tag, input int n, input int abort_at);
        int k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            @(negedge clk);
            k++;
            check(tag, sample(), exp_q.pop_front());
            abort = (k == abort_at);
        end
        abort = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        model_data = '0;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = OP_LOAD;
        cmd_amt    = '0;
        cmd_data   = '0;
        abort      = 1'b0;

        #12;
        check("reset_values", sample(), mk(1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", sample(), mk(1, 0, 0, 0, 0, 0, 0));

        issue(OP_LOAD, 5'd0, 8'hA5, 1'b0, 0);
        drain("load_a5", -1, 0);

        issue(OP_SHL, 5'd5, 8'h00, 1'b0, 0);
        drain("shl_5", -1, 0);

        issue(OP_SHR, 5'd18, 8'h00, 1'b0, 0);
        drain("shr_max", -1, 0);

        issue(OP_PINGPONG, 5'd3, 8'h00, 1'b0, 0);
        drain("pingpong_3", -1, 0);

        issue(OP_PINGPONG, 5'd0, 8'h00, 1'b0, 0);
        drain("pingpong_0", -1, 0);

        issue(OP_SHR, 5'd19, 8'h00, 1'b0, 0);
        drain("illegal_19", -1, 0);

        issue(OP_SHL, 5'd1, 8'h00, 1'b0, 0);
        drain("shl_1_after_err", -1, 0);

        issue(OP_SHL, 5'd10, 8'h00, 1'b0, 4);
        drain("shl_abort", -1, 4);

        // LOAD offered together with abort while idle is still accepted
        issue(OP_LOAD, 5'd0, 8'h3C, 1'b1, 0);
        drain("load_after_abort", -1, 0);

        // Reset asserted between edges in the middle of a SHL burst
        issue(OP_SHL, 5'd10, 8'h00, 1'b0, 0);
        drain("shl_pre_reset", 3, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_data = '0;
        exp_q.delete();
        check("async_reset_mid_shl", sample(), mk(1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;

        issue(OP_LOAD, 5'd0, 8'h5A, 1'b0, 0);
        drain("load_after_reset", -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
